cu_read_command_buffer: RTL and testbench

Queue between the compute unit's read engine control and the AFU command arbiter. It accepts read commands from the engine's `read_command_out`, buffers them in a FIFO, and requests arbitration. Each granted command goes out as one registered `CommandBufferLine`. Its `read_command_buffer_status` output feeds back to the read engine control as flow control, so the engine throttles on `alfull`.

---
 rtl/cu_read_command_buffer.sv | 123 ++++++++++++
 tb/tb_cu_read_command_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_read_command_buffer.sv
// Read-command FIFO between the compute unit's read engine control and the AFU command arbiter.
// Buffers engine commands, requests arbitration, and issues one registered line per grant.
package cu_read_command_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [7:0]  cu_id;
        logic [15:0] tag;
        logic [31:0] address;
        logic [7:0]  size;
    } CommandBufferLine;

    typedef struct packed {
        logic empty;
        logic full;
        logic alfull;
        logic valid;
    } BufferStatus;
endpackage

module cu_read_command_buffer
    import cu_read_command_buffer_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ALFULL_MARGIN = 4
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             enabled_in,
    input  CommandBufferLine read_command_in,
    input  logic             command_arbiter_grant_in,
    output logic             command_arbiter_request_out,
    output CommandBufferLine read_command_out,
    output BufferStatus      read_command_buffer_status,
    output logic             overflow_error_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    CommandBufferLine mem_q [DEPTH];

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             request_q;
    CommandBufferLine out_q, out_d;
    BufferStatus      status_q, status_d;
    logic             overflow_q;
    logic             push, pop;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        // Registered full gates the push, so a pop in the same cycle never frees a slot early.
        push     = read_command_in.valid && !status_q.full;
        case (state_q)
            IDLE: begin
                if (enabled_in && (count_q != '0)) state_d = REQ;
            end
            REQ: begin
                if (!enabled_in) begin
                    state_d = IDLE;
                end else if (command_arbiter_grant_in && (count_q != '0)) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = (enabled_in && (count_q != '0)) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        status_d.empty  = (count_d == '0);
        status_d.full   = (count_d == CNT_W'(DEPTH));
        status_d.alfull = (count_d >= CNT_W'(DEPTH - ALFULL_MARGIN));
        status_d.valid  = (count_d != '0);

        out_d = pop ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= read_command_in;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            request_q  <= 1'b0;
            out_q      <= '0;
            status_q   <= BufferStatus'(4'b1000);
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            request_q <= (state_d == REQ);
            out_q     <= out_d;
            status_q  <= status_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (read_command_in.valid && status_q.full) overflow_q <= 1'b1;
        end
    end

    assign command_arbiter_request_out = request_q;
    assign read_command_out            = out_q;
    assign read_command_buffer_status  = status_q;
    assign overflow_error_out          = overflow_q;

endmodule

// File: tb/tb_cu_read_command_buffer.sv
// Scoreboard bench for cu_read_command_buffer: randomized and directed traffic against a queue model.
module tb_cu_read_command_buffer;
    import cu_read_command_buffer_pkg::*;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic             clock = 1'b0;
    logic             rstn  = 1'b0;
    logic             en_drv = 1'b0;
    logic             grant_drv = 1'b0;
    CommandBufferLine cmd_drv = '0;
    logic             req_out;
    CommandBufferLine dut_out;
    BufferStatus      dut_st;
    logic             ovf_out;

    cu_read_command_buffer #(.DEPTH(DEPTH), .ALFULL_MARGIN(MARGIN)) dut (
        .clock                       (clock),
        .rstn                        (rstn),
        .enabled_in                  (en_drv),
        .read_command_in             (cmd_drv),
        .command_arbiter_grant_in    (grant_drv),
        .command_arbiter_request_out (req_out),
        .read_command_out            (dut_out),
        .read_command_buffer_status  (dut_st),
        .overflow_error_out          (ovf_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: accepted commands in order, plus running totals.
    CommandBufferLine exp_q[$];
    int   n_acc      = 0;
    int   n_issued   = 0;
    logic exp_ovf    = 1'b0;
    logic req_prev   = 1'b0;
    int   cyc        = 0;
    int   last_issue = -100;
    int   issue_cyc[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        exp_q.delete();
        n_acc      = 0;
        n_issued   = 0;
        exp_ovf    = 1'b0;
        req_prev   = 1'b0;
        last_issue = -100;
    endtask

    // Inputs change on the falling edge and hold across the next rising edge.
    task automatic step(input bit push, input logic [15:0] tag, input bit en, input bit gnt);
        CommandBufferLine c;
        @(negedge clock);
        en_drv    = en;
        grant_drv = gnt;
        if (push) begin
            c.valid   = 1'b1;
            c.cu_id   = 8'($urandom);
            c.tag     = tag;
            c.address = $urandom;
            c.size    = 8'($urandom);
            if ((n_acc - n_issued) < DEPTH) begin
                exp_q.push_back(c);
                n_acc++;
            end else begin
                exp_ovf = 1'b1;
            end
            cmd_drv = c;
        end else begin
            cmd_drv = '0;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step(0, 16'h0, 1, 1);
            k++;
        end
        step(0, 16'h0, 1, 1);
        step(0, 16'h0, 1, 1);
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_empty"}, dut_st.empty, 1'b1);
    endtask

    // Monitor: samples just after every rising edge.
    logic             m_exp_v;
    CommandBufferLine m_e;
    int               m_occ;
    logic [3:0]       m_exp_st;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (rstn) begin
                m_exp_v = req_prev && grant_drv && en_drv;
                chk("issue_valid", dut_out.valid, m_exp_v);
                if (dut_out.valid) begin
                    if (exp_q.size() == 0) begin
                        chk("issue_unexpected", dut_out, '0);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("issue_data", dut_out, m_e);
                    end
                    n_issued++;
                    chk("issue_spacing", (cyc - last_issue) >= 2, 1'b1);
                    last_issue = cyc;
                    issue_cyc.push_back(cyc);
                end else begin
                    chk("out_zero", dut_out, '0);
                end
                m_occ    = n_acc - n_issued;
                m_exp_st = {m_occ == 0, m_occ == DEPTH, m_occ >= DEPTH - MARGIN, m_occ != 0};
                chk("status", dut_st, m_exp_st);
                chk("overflow", ovf_out, exp_ovf);
                req_prev = req_out;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_request", req_out, 1'b0);
        chk("rst_out", dut_out, '0);
        chk("rst_status", dut_st, 4'b1000);
        chk("rst_overflow", ovf_out, 1'b0);
        model_reset();
        rstn = 1'b1;

        // Three commands, arbiter always granting
        issue_cyc.delete();
        step(1, 16'd1, 1, 1);
        step(1, 16'd2, 1, 1);
        chk("t1_req_after_push", req_out, 1'b0);
        step(1, 16'd3, 1, 1);
        chk("t1_req_next", req_out, 1'b1);
        drain("t1");
        chk("t1_issue_count", issue_cyc.size(), 3);
        if (issue_cyc.size() == 3) begin
            chk("t1_gap_a", issue_cyc[1] - issue_cyc[0], 2);
            chk("t1_gap_b", issue_cyc[2] - issue_cyc[1], 2);
        end

        // Fill without grants, then overflow
        for (int i = 1; i <= 17; i++) begin
            step(1, 16'(16'h100 + i), 1, 0);
            if (i >= 2) begin
                chk("t2_alfull", dut_st.alfull, (i - 1) >= (DEPTH - MARGIN));
                chk("t2_full", dut_st.full, (i - 1) == DEPTH);
            end
        end
        step(0, 16'h0, 1, 0);
        chk("t2_overflow", ovf_out, 1'b1);
        chk("t2_still_full", dut_st.full, 1'b1);

        // Full: push and grant-pop on the same edge
        step(1, 16'h200, 1, 1);
        step(0, 16'h0, 1, 0);
        chk("t3_full_after_pop", dut_st.full, 1'b0);
        chk("t3_alfull_after_pop", dut_st.alfull, 1'b1);
        step(1, 16'h201, 1, 0);
        step(0, 16'h0, 1, 0);
        chk("t3_refull", dut_st.full, 1'b1);
        drain("t3");

        // Random interleaving across many pointer wraps
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, 16'($urandom),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);
        end
        drain("t4");

        // Disable while requesting with four queued
        for (int i = 0; i < 4; i++) step(1, 16'(16'h300 + i), 0, 0);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);
        chk("t5_req_high", req_out, 1'b1);
        begin
            int issued_before;
            issued_before = n_issued;
            step(0, 16'h0, 0, 0);
            step(0, 16'h0, 0, 1);
            chk("t5_req_dropped", req_out, 1'b0);
            for (int i = 0; i < 8; i++) step(0, 16'h0, 0, $urandom_range(0, 1) == 1);
            chk("t5_no_issue", n_issued - issued_before, 0);
            chk("t5_retained", dut_st.empty, 1'b0);
            drain("t5");
            chk("t5_all_issued", n_issued - issued_before, 4);
        end

        // Reset while issuing, overflow set beforehand
        for (int i = 0; i < 17; i++) step(1, 16'(16'h400 + i), 0, 0);
        begin
            int k;
            k = 0;
            step(0, 16'h0, 1, 1);
            while (!dut_out.valid && k < 20) begin
                step(0, 16'h0, 1, 1);
                k++;
            end
            chk("t6_reached_issue", dut_out.valid, 1'b1);
        end
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_rst_request", req_out, 1'b0);
        chk("t6_rst_out", dut_out, '0);
        chk("t6_rst_status", dut_st, 4'b1000);
        chk("t6_rst_overflow", ovf_out, 1'b0);
        @(negedge clock);
        cmd_drv = '0;
        model_reset();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 1);
        chk("t6_post_empty", dut_st.empty, 1'b1);
        chk("t6_post_request", req_out, 1'b0);
        chk("t6_post_overflow", ovf_out, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
